mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Single-outstanding request arbiter between the instruction cache, the data cache and the AXI bridge's class-SRAM port. It grants one of three requesters (data write, data read, instruction read), issues the request downstream, and waits for completion before granting again. Read beats are routed back to their owner. A starvation counter bounds instruction-fetch latency under heavy data traffic.

## Interface
- STARVE_LIMIT, 8, number of IDLE cycles with an ungranted pending inst read before inst gets top priority (1..255)
- clk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- i_rd_req / i_rd_type / i_rd_addr  in  1/3/32  inst read request; type 3'b100 = 16 B line, else single beat of size type
- i_rd_rdy  out  1  inst request accepted this cycle
- i_ret_valid / i_ret_last / i_ret_data  out  1/1/32  inst return beat
- d_rd_req / d_rd_type / d_rd_addr  in  1/3/32  data read request
- d_rd_rdy  out  1  data read accepted
- d_ret_valid / d_ret_last / d_ret_data  out  1/1/32  data return beat
- d_wr_req / d_wr_type / d_wr_addr / d_wr_wstrb / d_wr_data  in  1/3/32/4/128  data write request
- d_wr_rdy  out  1  write accepted
- m_rd_req / m_rd_id / m_rd_type / m_rd_addr  out  1/1/3/32  downstream read; id 0 = inst, 1 = data
- m_rd_rdy  in  1  downstream read accepted
- m_ret_valid / m_ret_last / m_ret_data  in  1/1/32  downstream return beat
- m_wr_req / m_wr_type / m_wr_addr / m_wr_wstrb / m_wr_data  out  1/3/32/4/128  downstream write
- m_wr_rdy  in  1  downstream write accepted
- m_wr_done  in  1  write response received (bvalid & bready)
- proto_err  out  1  sticky: beat count disagrees with m_ret_last

## Operation
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT.
- IDLE grant selection (combinational, one winner):
  1. i_rd_req with starve_cnt >= STARVE_LIMIT
  2. d_wr_req
  3. d_rd_req
  4. i_rd_req
- The winner's *_rdy is high only in IDLE. All *_rdy are 0 outside IDLE.
- On accept (req & rdy), latch type, addr, id, and for writes wstrb/data. Then go to RD_ISSUE or WR_ISSUE.
- RD_ISSUE: m_rd_req = 1 from latched registers. On m_rd_rdy, go to RD_WAIT, clear beat_cnt, set expected beats (4 if type 3'b100, else 1).
- RD_WAIT: each m_ret_valid increments beat_cnt and is forwarded to the owner only. The non-owner's ret_valid stays 0.
  - Owner's ret_last = m_ret_last.
  - ret_data = m_ret_data when valid, else 32'b0.
  - On m_ret_valid & m_ret_last, go to IDLE.
- WR_ISSUE: m_wr_req = 1 with latched fields. On m_wr_rdy, go to WR_WAIT.
- WR_WAIT: on m_wr_done, go to IDLE.
- m_ret_valid outside RD_WAIT, or m_wr_done outside WR_WAIT: ignored, set proto_err.
- proto_err is also set when m_ret_last arrives on a beat other than the expected one, or when no last arrives by the expected beat. The FSM still leaves RD_WAIT only on m_ret_last.
- starve_cnt (8 bit, saturating):
  - +1 each IDLE cycle where i_rd_req = 1 and inst is not granted.
  - Cleared on inst grant.
  - Held outside IDLE.

## Timing
- Reset values: all *_rdy, *_ret_valid, *_ret_last, m_rd_req, m_wr_req, proto_err = 0; data/addr outputs = 0; state = IDLE; starve_cnt = 0.
- Accept at cycle N: m_*_req is high at N+1 (registered), and stays high until the cycle m_*_rdy is seen.
- Return path is combinational: m_ret_* at cycle M appears on the owner's ret_* at cycle M.
- After the final beat or m_wr_done at cycle M: state is IDLE at M+1, and a new grant is possible at M+1 (one-cycle turnaround).
- Simultaneous requests: exactly one rdy is high per cycle; losers hold req and are served later.
- m_rd_rdy in the same cycle m_rd_req first rises: the request leaves RD_ISSUE after one cycle.
- Reset mid-transaction: the FSM returns to IDLE and latched requests are dropped. The bridge is reset concurrently.

## Structure
- Package mem_arb_pkg holds:
  - state enum
  - TYPE_LINE = 3'b100
  - ID_INST = 1'b0, ID_DATA = 1'b1
  - LINE_BEATS = 4
  - STARVE_W = 8
- One sub-module, arb_starve_ctr: the saturating counter plus the threshold compare. Everything else is flat in mem_req_arbiter.

## Test plan
- Single inst line read at 0x1c000000: 4 beats 0x11..0x44, last on beat 4 -> i_ret_valid ×4, i_ret_last on 4th, d_ret_valid stays 0, IDLE one cycle later.
- d_wr_req, d_rd_req and i_rd_req all asserted in the same cycle -> write granted first, then data read, then inst; m_wr_data = latched 128-bit value.
- Continuous d_rd_req stream with i_rd_req held, STARVE_LIMIT = 8 -> inst granted after exactly 8 ungranted IDLE cycles; starve_cnt then 0.
- m_rd_rdy held low for 5 cycles -> m_rd_req and m_rd_addr stay stable; no *_rdy asserted during the stall.
- Single-beat data read (type 3'b010) returning m_ret_last on beat 2, and a stray m_ret_valid in IDLE -> proto_err = 1 and sticky until reset.
- aresetn low during RD_WAIT of a line read -> state IDLE, all outputs at reset values the next cycle; a fresh i_rd_req is accepted right after reset is released.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_WR_WAIT
  } state_e;

  localparam logic [2:0]  TYPE_LINE  = 3'b100;
  localparam logic        ID_INST    = 1'b0;
  localparam logic        ID_DATA    = 1'b1;
  localparam int unsigned LINE_BEATS = 4;
  localparam int unsigned STARVE_W   = 8;
  localparam int unsigned BEAT_W     = 3;

  // Request captured on grant and replayed downstream.
  typedef struct packed {
    logic [2:0]   kind;
    logic [31:0]  addr;
    logic         id;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } req_t;

  function automatic logic [BEAT_W-1:0] beats_for(input logic [2:0] kind);
    return (kind == TYPE_LINE) ? BEAT_W'(LINE_BEATS) : BEAT_W'(1);
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of IDLE cycles an inst read waited, with threshold flag.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 8
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                inc,
  input  logic                clr,
  output logic [STARVE_W-1:0] cnt,
  output logic                starved
);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + STARVE_W'(1);
    end
  end

  assign starved = (cnt >= STARVE_W'(LIMIT));

endmodule

// File: rtl/mem_req_arbiter.sv
// Single-outstanding arbiter: inst read, data read and data write share one
// downstream port; read beats are steered back to the owning requester.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         i_rd_req,
  input  logic [2:0]   i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  output logic         i_ret_last,
  output logic [31:0]  i_ret_data,
  input  logic         d_rd_req,
  input  logic [2:0]   d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic         d_ret_last,
  output logic [31:0]  d_ret_data,
  input  logic         d_wr_req,
  input  logic [2:0]   d_wr_type,
  input  logic [31:0]  d_wr_addr,
  input  logic [3:0]   d_wr_wstrb,
  input  logic [127:0] d_wr_data,
  output logic         d_wr_rdy,
  output logic         m_rd_req,
  output logic         m_rd_id,
  output logic [2:0]   m_rd_type,
  output logic [31:0]  m_rd_addr,
  input  logic         m_rd_rdy,
  input  logic         m_ret_valid,
  input  logic         m_ret_last,
  input  logic [31:0]  m_ret_data,
  output logic         m_wr_req,
  output logic [2:0]   m_wr_type,
  output logic [31:0]  m_wr_addr,
  output logic [3:0]   m_wr_wstrb,
  output logic [127:0] m_wr_data,
  input  logic         m_wr_rdy,
  input  logic         m_wr_done,
  output logic         proto_err
);

  state_e              state;
  state_e              state_nx;
  req_t                lat;
  logic                gnt_i;
  logic                gnt_dr;
  logic                gnt_dw;
  logic                starved;
  logic [STARVE_W-1:0] starve_cnt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [BEAT_W-1:0]   beat_exp;
  logic [BEAT_W-1:0]   beat_num;
  logic                rd_wait;
  logic                err_set;

  always_ff @(posedge clk) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Grant selection and next state; only IDLE can grant.
  always_comb begin
    state_nx = state;
    gnt_i    = 1'b0;
    gnt_dr   = 1'b0;
    gnt_dw   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (aresetn) begin
          if (i_rd_req && starved) gnt_i  = 1'b1;
          else if (d_wr_req)       gnt_dw = 1'b1;
          else if (d_rd_req)       gnt_dr = 1'b1;
          else if (i_rd_req)       gnt_i  = 1'b1;
        end
        if (gnt_dw)               state_nx = ST_WR_ISSUE;
        else if (gnt_i || gnt_dr) state_nx = ST_RD_ISSUE;
      end
      ST_RD_ISSUE: if (m_rd_rdy)                  state_nx = ST_RD_WAIT;
      ST_RD_WAIT:  if (m_ret_valid && m_ret_last) state_nx = ST_IDLE;
      ST_WR_ISSUE: if (m_wr_rdy)                  state_nx = ST_WR_WAIT;
      ST_WR_WAIT:  if (m_wr_done)                 state_nx = ST_IDLE;
      default:                                    state_nx = ST_IDLE;
    endcase
  end

  assign i_rd_rdy = gnt_i;
  assign d_rd_rdy = gnt_dr;
  assign d_wr_rdy = gnt_dw;
  assign m_rd_req = (state == ST_RD_ISSUE);
  assign m_wr_req = (state == ST_WR_ISSUE);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      lat <= '0;
    end else if (gnt_dw) begin
      lat <= '{kind: d_wr_type, addr: d_wr_addr, id: ID_DATA,
               wstrb: d_wr_wstrb, data: d_wr_data};
    end else if (gnt_dr) begin
      lat.kind <= d_rd_type;
      lat.addr <= d_rd_addr;
      lat.id   <= ID_DATA;
    end else if (gnt_i) begin
      lat.kind <= i_rd_type;
      lat.addr <= i_rd_addr;
      lat.id   <= ID_INST;
    end
  end

  assign m_rd_id    = lat.id;
  assign m_rd_type  = lat.kind;
  assign m_rd_addr  = lat.addr;
  assign m_wr_type  = lat.kind;
  assign m_wr_addr  = lat.addr;
  assign m_wr_wstrb = lat.wstrb;
  assign m_wr_data  = lat.data;

  // Return beats pass straight through to the owner only.
  assign rd_wait     = (state == ST_RD_WAIT);
  assign i_ret_valid = rd_wait && m_ret_valid && (lat.id == ID_INST);
  assign d_ret_valid = rd_wait && m_ret_valid && (lat.id == ID_DATA);
  assign i_ret_last  = i_ret_valid && m_ret_last;
  assign d_ret_last  = d_ret_valid && m_ret_last;
  assign i_ret_data  = i_ret_valid ? m_ret_data : 32'b0;
  assign d_ret_data  = d_ret_valid ? m_ret_data : 32'b0;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      beat_cnt <= '0;
      beat_exp <= '0;
    end else if ((state == ST_RD_ISSUE) && m_rd_rdy) begin
      beat_cnt <= '0;
      beat_exp <= beats_for(lat.kind);
    end else if (rd_wait && m_ret_valid && (beat_cnt != '1)) begin
      beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end

  // A beat is bad when its last flag disagrees with being the expected final beat.
  assign beat_num = beat_cnt + BEAT_W'(1);
  assign err_set  = (m_ret_valid && !rd_wait)
                 || (m_wr_done && (state != ST_WR_WAIT))
                 || (rd_wait && m_ret_valid && (m_ret_last != (beat_num == beat_exp)));

  always_ff @(posedge clk) begin
    if (!aresetn)     proto_err <= 1'b0;
    else if (err_set) proto_err <= 1'b1;
  end

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .aresetn (aresetn),
    .inc     ((state == ST_IDLE) && i_rd_req && !gnt_i),
    .clr     (gnt_i),
    .cnt     (starve_cnt),
    .starved (starved)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         i_rd_req, i_rd_rdy, i_ret_valid, i_ret_last;
  logic [2:0]   i_rd_type;
  logic [31:0]  i_rd_addr, i_ret_data;
  logic         d_rd_req, d_rd_rdy, d_ret_valid, d_ret_last;
  logic [2:0]   d_rd_type;
  logic [31:0]  d_rd_addr, d_ret_data;
  logic         d_wr_req, d_wr_rdy;
  logic [2:0]   d_wr_type;
  logic [31:0]  d_wr_addr;
  logic [3:0]   d_wr_wstrb;
  logic [127:0] d_wr_data;
  logic         m_rd_req, m_rd_id, m_rd_rdy, m_ret_valid, m_ret_last;
  logic [2:0]   m_rd_type;
  logic [31:0]  m_rd_addr, m_ret_data;
  logic         m_wr_req, m_wr_rdy, m_wr_done;
  logic [2:0]   m_wr_type;
  logic [31:0]  m_wr_addr;
  logic [3:0]   m_wr_wstrb;
  logic [127:0] m_wr_data;
  logic         proto_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .aresetn(aresetn),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
    .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .m_rd_req(m_rd_req), .m_rd_id(m_rd_id), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr),
    .m_rd_rdy(m_rd_rdy), .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last),
    .m_ret_data(m_ret_data), .m_wr_req(m_wr_req), .m_wr_type(m_wr_type),
    .m_wr_addr(m_wr_addr), .m_wr_wstrb(m_wr_wstrb), .m_wr_data(m_wr_data),
    .m_wr_rdy(m_wr_rdy), .m_wr_done(m_wr_done), .proto_err(proto_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plays the downstream side of one read: accept the issue, then return beats.
  task automatic finish_read(input int nbeats, input int last_beat, input logic [31:0] base);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (m_rd_req === 1'b1) begin
        m_rd_rdy = 1'b1;
        seen = 1'b1;
      end
      step();
      m_rd_rdy = 1'b0;
    end
    tests++; if (!seen || m_rd_req !== 1'b0) begin fails++; $display("FAIL rd_issue seen=%0d m_rd_req=%b exp seen=1 m_rd_req=0", seen, m_rd_req); end
    for (int k = 1; k <= nbeats; k++) begin
      m_ret_valid = 1'b1;
      m_ret_data  = base + 32'(k);
      m_ret_last  = (k == last_beat);
      step();
    end
    m_ret_valid = 1'b0;
    m_ret_last  = 1'b0;
    m_ret_data  = 32'h0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    i_rd_req = 1'b1; i_rd_type = 3'b010; i_rd_addr = 32'h0;
    d_rd_req = 1'b0; d_rd_type = 3'b0; d_rd_addr = 32'h0;
    d_wr_req = 1'b0; d_wr_type = 3'b0; d_wr_addr = 32'h0; d_wr_wstrb = 4'h0; d_wr_data = 128'h0;
    m_rd_rdy = 1'b0; m_ret_valid = 1'b0; m_ret_last = 1'b0; m_ret_data = 32'h0;
    m_wr_rdy = 1'b0; m_wr_done = 1'b0;
    step(); step();
    tests++; if (i_rd_rdy !== 1'b0) begin fails++; $display("FAIL reset_i_rdy got %b exp 0", i_rd_rdy); end
    tests++; if (m_rd_req !== 1'b0 || m_wr_req !== 1'b0) begin fails++; $display("FAIL reset_m_req got %b%b exp 00", m_rd_req, m_wr_req); end
    tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto_err got %b exp 0", proto_err); end
    tests++; if (m_rd_addr !== 32'h0 || m_wr_data !== 128'h0) begin fails++; $display("FAIL reset_data got %h %h exp 0", m_rd_addr, m_wr_data); end
    tests++; if (dut.starve_cnt !== 8'd0) begin fails++; $display("FAIL reset_starve got %0d exp 0", dut.starve_cnt); end
    i_rd_req = 1'b0;
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_inst_line();
    i_rd_req = 1'b1; i_rd_type = TYPE_LINE; i_rd_addr = 32'h1c00_0000;
    #1;
    tests++; if (i_rd_rdy !== 1'b1) begin fails++; $display("FAIL line_i_rdy got %b exp 1", i_rd_rdy); end
    step();
    i_rd_req = 1'b0;
    #1;
    tests++; if (m_rd_req !== 1'b1 || m_rd_id !== 1'b0) begin fails++; $display("FAIL line_issue got req=%b id=%b exp 1/0", m_rd_req, m_rd_id); end
    tests++; if (m_rd_addr !== 32'h1c00_0000 || m_rd_type !== 3'b100) begin fails++; $display("FAIL line_fields got %h/%b exp 1c000000/100", m_rd_addr, m_rd_type); end
    m_rd_rdy = 1'b1;
    step();
    m_rd_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      m_ret_valid = 1'b1;
      m_ret_data  = 32'(k * 32'h11);
      m_ret_last  = (k == 4);
      #1;
      tests++; if (i_ret_valid !== 1'b1 || i_ret_last !== (k == 4)) begin fails++; $display("FAIL line_beat%0d got v=%b l=%b exp 1/%0d", k, i_ret_valid, i_ret_last, (k == 4)); end
      tests++; if (i_ret_data !== 32'(k * 32'h11) || d_ret_valid !== 1'b0) begin fails++; $display("FAIL line_data%0d got %h dv=%b exp %h dv=0", k, i_ret_data, d_ret_valid, 32'(k * 32'h11)); end
      step();
    end
    m_ret_valid = 1'b0; m_ret_last = 1'b0; m_ret_data = 32'h0;
    #1;
    tests++; if (dut.state !== ST_IDLE || proto_err !== 1'b0) begin fails++; $display("FAIL line_done got state=%0d err=%b exp IDLE/0", dut.state, proto_err); end
  endtask

  task automatic test_priority();
    d_wr_req = 1'b1; d_wr_type = 3'b010; d_wr_addr = 32'h100; d_wr_wstrb = 4'hf;
    d_wr_data = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    d_rd_req = 1'b1; d_rd_type = 3'b010; d_rd_addr = 32'h200;
    i_rd_req = 1'b1; i_rd_type = 3'b010; i_rd_addr = 32'h300;
    #1;
    tests++; if ({d_wr_rdy, d_rd_rdy, i_rd_rdy} !== 3'b100) begin fails++; $display("FAIL prio_wr got %b exp 100", {d_wr_rdy, d_rd_rdy, i_rd_rdy}); end
    step();
    d_wr_req = 1'b0; d_wr_data = 128'h0;
    #1;
    tests++; if (m_wr_req !== 1'b1 || m_wr_data !== 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210) begin fails++; $display("FAIL prio_wr_issue got req=%b data=%h", m_wr_req, m_wr_data); end
    tests++; if (m_wr_addr !== 32'h100 || m_wr_wstrb !== 4'hf || {d_rd_rdy, i_rd_rdy} !== 2'b00) begin fails++; $display("FAIL prio_wr_fields got %h %h rdy=%b%b exp 100 f 00", m_wr_addr, m_wr_wstrb, d_rd_rdy, i_rd_rdy); end
    m_wr_rdy = 1'b1; step(); m_wr_rdy = 1'b0;
    m_wr_done = 1'b1; step(); m_wr_done = 1'b0;
    #1;
    tests++; if ({d_wr_rdy, d_rd_rdy, i_rd_rdy} !== 3'b010) begin fails++; $display("FAIL prio_rd got %b exp 010", {d_wr_rdy, d_rd_rdy, i_rd_rdy}); end
    step();
    d_rd_req = 1'b0;
    tests++; if (m_rd_id !== 1'b1 || m_rd_addr !== 32'h200) begin fails++; $display("FAIL prio_rd_issue got %b %h exp 1 200", m_rd_id, m_rd_addr); end
    finish_read(1, 1, 32'h0);
    #1;
    tests++; if (i_rd_rdy !== 1'b1) begin fails++; $display("FAIL prio_inst got %b exp 1", i_rd_rdy); end
    step();
    i_rd_req = 1'b0;
    tests++; if (m_rd_id !== 1'b0 || m_rd_addr !== 32'h300) begin fails++; $display("FAIL prio_inst_issue got %b %h exp 0 300", m_rd_id, m_rd_addr); end
    tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL prio_wr_err got %b exp 0", proto_err); end
    finish_read(1, 1, 32'h0);
  endtask

  task automatic test_starve();
    d_rd_req = 1'b1; d_rd_type = 3'b010; d_rd_addr = 32'h400;
    i_rd_req = 1'b1; i_rd_type = 3'b010; i_rd_addr = 32'h500;
    for (int g = 0; g <= 8; g++) begin
      #1;
      tests++; if (i_rd_rdy !== (g == 8) || d_rd_rdy !== (g != 8)) begin fails++; $display("FAIL starve_grant%0d got i=%b d=%b exp i=%0d", g, i_rd_rdy, d_rd_rdy, (g == 8)); end
      if (g == 8) begin
        tests++; if (dut.starve_cnt !== 8'd8) begin fails++; $display("FAIL starve_cnt_pre got %0d exp 8", dut.starve_cnt); end
      end
      step();
      if (g == 8) i_rd_req = 1'b0;
      finish_read(1, 1, 32'h0);
    end
    d_rd_req = 1'b0;
    #1;
    tests++; if (dut.starve_cnt !== 8'd0) begin fails++; $display("FAIL starve_cnt_post got %0d exp 0", dut.starve_cnt); end
  endtask

  task automatic test_stall();
    d_rd_req = 1'b1; d_rd_type = 3'b010; d_rd_addr = 32'h1234_5678;
    step();
    d_rd_req = 1'b0;
    i_rd_req = 1'b1; d_wr_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++; if (m_rd_req !== 1'b1 || m_rd_addr !== 32'h1234_5678) begin fails++; $display("FAIL stall%0d got req=%b addr=%h exp 1 12345678", c, m_rd_req, m_rd_addr); end
      tests++; if ({i_rd_rdy, d_rd_rdy, d_wr_rdy} !== 3'b000) begin fails++; $display("FAIL stall_rdy%0d got %b exp 000", c, {i_rd_rdy, d_rd_rdy, d_wr_rdy}); end
      step();
    end
    i_rd_req = 1'b0; d_wr_req = 1'b0;
    finish_read(1, 1, 32'h0);
  endtask

  task automatic test_proto_err();
    aresetn = 1'b0; step(); aresetn = 1'b1;
    d_rd_req = 1'b1; d_rd_type = 3'b010; d_rd_addr = 32'h40;
    step();
    d_rd_req = 1'b0;
    m_rd_rdy = 1'b1; step(); m_rd_rdy = 1'b0;
    m_ret_valid = 1'b1; m_ret_last = 1'b0; m_ret_data = 32'haa;
    #1;
    tests++; if (d_ret_valid !== 1'b1 || proto_err !== 1'b0) begin fails++; $display("FAIL late_beat1 got v=%b err=%b exp 1/0", d_ret_valid, proto_err); end
    step();
    m_ret_last = 1'b1; m_ret_data = 32'hbb;
    #1;
    tests++; if (proto_err !== 1'b1 || d_ret_last !== 1'b1) begin fails++; $display("FAIL late_err got err=%b last=%b exp 1/1", proto_err, d_ret_last); end
    step();
    m_ret_valid = 1'b0; m_ret_last = 1'b0; m_ret_data = 32'h0;
    step(); step();
    tests++; if (dut.state !== ST_IDLE || proto_err !== 1'b1) begin fails++; $display("FAIL late_sticky got state=%0d err=%b exp IDLE/1", dut.state, proto_err); end
    aresetn = 1'b0; step(); aresetn = 1'b1;
    tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL err_clear got %b exp 0", proto_err); end
    m_ret_valid = 1'b1; m_ret_data = 32'hdead;
    #1;
    tests++; if (i_ret_valid !== 1'b0 || d_ret_valid !== 1'b0 || d_ret_data !== 32'h0) begin fails++; $display("FAIL stray_fwd got %b %b %h exp 0 0 0", i_ret_valid, d_ret_valid, d_ret_data); end
    step();
    m_ret_valid = 1'b0; m_ret_data = 32'h0;
    step(); step();
    tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL stray_err got %b exp 1", proto_err); end
  endtask

  task automatic test_reset_mid();
    aresetn = 1'b0; step(); aresetn = 1'b1;
    i_rd_req = 1'b1; i_rd_type = TYPE_LINE; i_rd_addr = 32'h1c00_0020;
    step();
    i_rd_req = 1'b0;
    m_rd_rdy = 1'b1; step(); m_rd_rdy = 1'b0;
    m_ret_valid = 1'b1; m_ret_last = 1'b0; m_ret_data = 32'h1;
    step(); step();
    m_ret_valid = 1'b0; m_ret_data = 32'h0;
    aresetn = 1'b0;
    step();
    tests++; if (dut.state !== ST_IDLE || m_rd_req !== 1'b0 || i_ret_valid !== 1'b0) begin fails++; $display("FAIL mid_state got state=%0d req=%b v=%b exp IDLE 0 0", dut.state, m_rd_req, i_ret_valid); end
    tests++; if (m_rd_addr !== 32'h0 || proto_err !== 1'b0 || i_rd_rdy !== 1'b0) begin fails++; $display("FAIL mid_outs got addr=%h err=%b rdy=%b exp 0 0 0", m_rd_addr, proto_err, i_rd_rdy); end
    aresetn = 1'b1;
    i_rd_req = 1'b1; i_rd_type = 3'b010; i_rd_addr = 32'h1c00_0040;
    #1;
    tests++; if (i_rd_rdy !== 1'b1) begin fails++; $display("FAIL mid_regrant got %b exp 1", i_rd_rdy); end
    step();
    i_rd_req = 1'b0;
    tests++; if (m_rd_req !== 1'b1 || m_rd_addr !== 32'h1c00_0040) begin fails++; $display("FAIL mid_issue got %b %h exp 1 1c000040", m_rd_req, m_rd_addr); end
    finish_read(1, 1, 32'h0);
    tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL mid_err got %b exp 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_inst_line();
    test_priority();
    test_starve();
    test_stall();
    test_proto_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
